// File: rtl/mbox_req_arb_if.sv
// Request/grant bundle between the MBOX requesters and mbox_req_arb.
// master drives requests and completions; slave is the arbiter.
interface mbox_req_arb_if;
    logic       ebReq;
    logic       chReq;
    logic       swReq;
    logic       mbDone;
    logic       swDone;
    logic       errClr;
    logic       ebGnt;
    logic       chGnt;
    logic       swGnt;
    logic       mbStart;
    logic [1:0] mbSel;
    logic       busy;
    logic       nxmErr;

    modport master (
        output ebReq, chReq, swReq, mbDone, swDone, errClr,
        input  ebGnt, chGnt, swGnt, mbStart, mbSel, busy, nxmErr
    );

    modport slave (
        input  ebReq, chReq, swReq, mbDone, swDone, errClr,
        output ebGnt, chGnt, swGnt, mbStart, mbSel, busy, nxmErr
    );
endinterface

// File: rtl/mbox_req_arb.sv
// MBOX port arbiter: fixed priority SW > CH > EB, one cycle per grant, timeout abort.
// Optional EBOX anti-starvation override when MBOX_ARB_FAIR_EN is defined.
module mbox_req_arb #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic           mboxClk,
    input  logic           mboxRstN,
    mbox_req_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_SWEEP
    } state_t;

    localparam logic [9:0] TMO_LIM = 10'(TIMEOUT_CYC);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 1023 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_chk
        $error("mbox_req_arb: TIMEOUT_CYC or STARVE_MAX out of range");
    end

    state_t     r_state;
    logic [9:0] r_tmo;
    logic       r_ebGnt;
    logic       r_chGnt;
    logic       r_swGnt;
    logic       r_mbStart;
    logic [1:0] r_mbSel;
    logic       r_busy;
    logic       r_nxmErr;

    logic [9:0] w_tmoNext;
    logic       w_tmoAbort;
    logic       w_ebForce;
    logic       w_pickSw;
    logic       w_pickCh;
    logic       w_pickEb;

`ifdef MBOX_ARB_FAIR_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] r_starve;

    assign w_ebForce = bus.ebReq && (r_starve >= STARVE_LIM);

    // Counts CH/SW wins that bypassed a pending EBOX request; saturates at 15.
    always_ff @(posedge mboxClk or negedge mboxRstN) begin
        if (!mboxRstN) begin
            r_starve <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_pickEb) begin
                r_starve <= '0;
            end else if ((w_pickCh || w_pickSw) && bus.ebReq && (r_starve != '1)) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end
`else
    assign w_ebForce = 1'b0;
`endif

    always_comb begin
        w_pickSw   = 1'b0;
        w_pickCh   = 1'b0;
        w_pickEb   = 1'b0;
        w_tmoNext  = (r_tmo == '1) ? r_tmo : r_tmo + 10'd1;
        w_tmoAbort = (r_state == S_BUSY) && !bus.mbDone && (w_tmoNext >= TMO_LIM);
        if (w_ebForce) begin
            w_pickEb = 1'b1;
        end else if (bus.swReq) begin
            w_pickSw = 1'b1;
        end else if (bus.chReq) begin
            w_pickCh = 1'b1;
        end else begin
            w_pickEb = bus.ebReq;
        end
    end

    always_ff @(posedge mboxClk or negedge mboxRstN) begin
        if (!mboxRstN) begin
            r_state   <= S_IDLE;
            r_tmo     <= '0;
            r_ebGnt   <= 1'b0;
            r_chGnt   <= 1'b0;
            r_swGnt   <= 1'b0;
            r_mbStart <= 1'b0;
            r_mbSel   <= 2'd0;
            r_busy    <= 1'b0;
            r_nxmErr  <= 1'b0;
        end else begin
            r_mbStart <= 1'b0;
            // Timeout set takes precedence over a simultaneous clear.
            r_nxmErr  <= w_tmoAbort || (r_nxmErr && !bus.errClr);
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (w_pickSw) begin
                        r_state <= S_SWEEP;
                        r_swGnt <= 1'b1;
                        r_mbSel <= 2'd3;
                        r_busy  <= 1'b1;
                    end else if (w_pickCh || w_pickEb) begin
                        r_state   <= S_BUSY;
                        r_chGnt   <= w_pickCh;
                        r_ebGnt   <= w_pickEb;
                        r_mbSel   <= w_pickCh ? 2'd2 : 2'd1;
                        r_busy    <= 1'b1;
                        r_mbStart <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (bus.mbDone || w_tmoAbort) begin
                        r_state <= S_IDLE;
                        r_ebGnt <= 1'b0;
                        r_chGnt <= 1'b0;
                        r_mbSel <= 2'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tmo <= w_tmoNext;
                    end
                end
                S_SWEEP: begin
                    if (bus.swDone) begin
                        r_state <= S_IDLE;
                        r_swGnt <= 1'b0;
                        r_mbSel <= 2'd0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ebGnt <= 1'b0;
                    r_chGnt <= 1'b0;
                    r_swGnt <= 1'b0;
                    r_mbSel <= 2'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ebGnt   = r_ebGnt;
    assign bus.chGnt   = r_chGnt;
    assign bus.swGnt   = r_swGnt;
    assign bus.mbStart = r_mbStart;
    assign bus.mbSel   = r_mbSel;
    assign bus.busy    = r_busy;
    assign bus.nxmErr  = r_nxmErr;
endmodule

// File: tb/tb_mbox_req_arb.sv
// Directed bench for mbox_req_arb with TIMEOUT_CYC=8.
// Observed word packs {ebGnt,chGnt,swGnt,mbStart,mbSel,busy,nxmErr}.
module tb_mbox_req_arb;
    logic mboxClk;
    logic mboxRstN;
    int   total;
    int   bad;

    mbox_req_arb_if bus ();

    mbox_req_arb #(
        .TIMEOUT_CYC (8),
        .STARVE_MAX  (4)
    ) dut (
        .mboxClk  (mboxClk),
        .mboxRstN (mboxRstN),
        .bus      (bus)
    );

    initial mboxClk = 1'b0;
    always #5 mboxClk = ~mboxClk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] w_obs;
    assign w_obs = {bus.ebGnt, bus.chGnt, bus.swGnt, bus.mbStart, bus.mbSel, bus.busy, bus.nxmErr};

    localparam logic [7:0] O_IDLE = 8'b000_0_00_0_0;
    localparam logic [7:0] O_ERR  = 8'b000_0_00_0_1;
    localparam logic [7:0] O_CHS  = 8'b010_1_10_1_0;
    localparam logic [7:0] O_CHH  = 8'b010_0_10_1_0;
    localparam logic [7:0] O_EBS  = 8'b100_1_01_1_0;
    localparam logic [7:0] O_EBH  = 8'b100_0_01_1_0;
    localparam logic [7:0] O_SW   = 8'b001_0_11_1_0;

    typedef struct {
        logic       eb;
        logic       ch;
        logic       sw;
        logic       md;
        logic       sd;
        logic       ec;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge mboxClk);
        #1;
    endtask

    task automatic drive(input logic eb, input logic ch, input logic sw,
                         input logic md, input logic sd, input logic ec);
        bus.ebReq  = eb;
        bus.chReq  = ch;
        bus.swReq  = sw;
        bus.mbDone = md;
        bus.swDone = sd;
        bus.errClr = ec;
    endtask

    initial begin
        logic [2:0] exp_g;
        total = 0;
        bad   = 0;

        // eb ch sw md sd ec -> outputs after the edge
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_CHS};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_CHH};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_CHH};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_EBS};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_SW};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_SW};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_SW};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_IDLE};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_CHS};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_SW};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_IDLE};

        mboxRstN = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_outputs", w_obs, O_IDLE);
        @(negedge mboxClk);
        mboxRstN = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].eb, vecs[i].ch, vecs[i].sw, vecs[i].md, vecs[i].sd, vecs[i].ec);
            step();
            chk($sformatf("vec%0d", i), w_obs, vecs[i].exp);
        end

        // Timeout: 8 BUSY cycles without mbDone, request withdrawn after grant
        drive(1, 0, 0, 0, 0, 0);
        step();
        chk("tmo_start", w_obs, O_EBS);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 2; k <= 8; k++) begin
            step();
            chk($sformatf("tmo_hold%0d", k), w_obs, O_EBH);
        end
        step();
        chk("tmo_abort", w_obs, O_ERR);
        step();
        chk("tmo_sticky", w_obs, O_ERR);
        drive(0, 0, 0, 0, 0, 1);
        step();
        chk("tmo_clear", w_obs, O_IDLE);

        // Timeout with errClr asserted on the abort edge: set wins
        drive(1, 0, 0, 0, 0, 0);
        step();
        chk("setwin_start", w_obs, O_EBS);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 2; k <= 8; k++) step();
        chk("setwin_hold8", w_obs, O_EBH);
        drive(0, 0, 0, 0, 0, 1);
        step();
        chk("setwin_abort", w_obs, O_ERR);
        step();
        chk("setwin_clear", w_obs, O_IDLE);

        // mbDone on the exact timeout cycle: no error
        drive(1, 0, 0, 0, 0, 0);
        step();
        chk("coll_start", w_obs, O_EBS);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 2; k <= 8; k++) step();
        chk("coll_hold8", w_obs, O_EBH);
        drive(0, 0, 0, 1, 0, 0);
        step();
        chk("coll_done", w_obs, O_IDLE);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("coll_after", w_obs, O_IDLE);

        // Fairness: ch and eb held, each grant completed on its first BUSY cycle
        for (int g = 0; g < 6; g++) begin
            drive(1, 1, 0, 0, 0, 0);
            step();
`ifdef MBOX_ARB_FAIR_EN
            exp_g = (g == 4) ? 3'b100 : 3'b010;
`else
            exp_g = 3'b010;
`endif
            chk($sformatf("fair_gnt%0d", g), {5'b0, w_obs[7:5]}, {5'b0, exp_g});
            drive(1, 1, 0, 1, 0, 0);
            step();
            chk($sformatf("fair_gap%0d", g), w_obs, O_IDLE);
        end

        // Asynchronous reset in the middle of a BUSY cycle
        drive(1, 0, 0, 0, 0, 0);
        step();
        chk("rst_pre", w_obs, O_EBS);
        #2;
        mboxRstN = 1'b0;
        #1;
        chk("rst_async", w_obs, O_IDLE);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge mboxClk);
        mboxRstN = 1'b1;
        step();
        chk("rst_idle1", w_obs, O_IDLE);
        step();
        chk("rst_idle2", w_obs, O_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
